// File: rtl/ts_q_pkg.sv
// Shared constants and types for the timestamp queue: entry width, status bit
// positions and the default depth.
package ts_q_pkg;

    localparam int ENTRY_W       = 56;
    localparam int SEC_KEEP_W    = 18;
    localparam int NS_W          = 38;
    localparam int SEC_W         = 48;
    localparam int CNT_W         = 5;
    localparam int DEFAULT_DEPTH = 16;

    localparam int STAT_OVF  = 7;
    localparam int STAT_UDF  = 6;
    localparam int STAT_FULL = 5;
    localparam int CNT_MSB   = 4;
    localparam int CNT_LSB   = 0;

    typedef logic [ENTRY_W-1:0] entry_t;

    // Entry layout: low 18 seconds bits on top of the full {ns, nsf} field.
    function automatic entry_t make_entry(input logic [SEC_W-1:0] sec,
                                          input logic [NS_W-1:0]  ns);
        return {sec[SEC_KEEP_W-1:0], ns};
    endfunction

endpackage

// File: rtl/ts_queue_if.sv
// Capture / pop / status bundle between the timestamp queue and its user.
interface ts_queue_if;
    import ts_q_pkg::*;

    logic                capture_in;
    logic [NS_W-1:0]     time_reg_ns_in;
    logic [SEC_W-1:0]    time_reg_sec_in;
    logic                q_rst_in;
    logic                q_rd_en_in;
    logic [ENTRY_W-1:0]  q_data_out;
    logic [7:0]          q_stat_out;

    modport slave (
        input  capture_in, time_reg_ns_in, time_reg_sec_in, q_rst_in, q_rd_en_in,
        output q_data_out, q_stat_out
    );

    modport master (
        output capture_in, time_reg_ns_in, time_reg_sec_in, q_rst_in, q_rd_en_in,
        input  q_data_out, q_stat_out
    );
endinterface

// File: rtl/ts_q_mem.sv
// Queue storage: DEPTH x ENTRY_W register array, one synchronous write port and
// one combinational read port, no reset (stale contents are masked by the count).
module ts_q_mem
    import ts_q_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  entry_t        wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output entry_t        rd_data_o
);

    entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ts_queue.sv
// Timestamp capture queue: snapshots the RTC on each capture strobe into a
// first-word-fall-through FIFO with sticky overflow/underflow flags.
module ts_queue
    import ts_q_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    ts_queue_if.slave   bus
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             full_q,   full_d;
    logic             ovf_q,    ovf_d;
    logic             udf_q,    udf_d;

    logic   is_empty;
    logic   pop_ok;
    logic   cap_ok;
    entry_t head_data;
    entry_t cap_entry;

    logic unused_sec_hi;
    assign unused_sec_hi = ^bus.time_reg_sec_in[SEC_W-1:SEC_KEEP_W];

    assign is_empty  = (count_q == '0);
    assign pop_ok    = bus.q_rd_en_in && !is_empty;
    // A full queue still accepts a capture when a pop frees the head slot this edge.
    assign cap_ok    = bus.capture_in && (!full_q || pop_ok);
    assign cap_entry = make_entry(bus.time_reg_sec_in, bus.time_reg_ns_in);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        full_d   = full_q;

        if (bus.q_rst_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
            full_d   = 1'b0;
        end else begin
            if (cap_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (cap_ok && !pop_ok) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_ok && !cap_ok) begin
                count_d = count_q - CNT_W'(1);
            end
            if (bus.capture_in && !cap_ok) begin
                ovf_d = 1'b1;
            end
            if (bus.q_rd_en_in && is_empty) begin
                udf_d = 1'b1;
            end
            full_d = (count_d == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    ts_q_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (cap_ok && !bus.q_rst_in),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (cap_entry),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (head_data)
    );

    assign bus.q_data_out = is_empty ? '0 : head_data;
    assign bus.q_stat_out = {ovf_q, udf_q, full_q, count_q};

endmodule

// File: tb/tb_ts_queue.sv
// Directed self-checking bench for ts_queue: fill/overflow, full capture+pop,
// underflow, wrap-around ordering, queue clear and asynchronous reset.
module tb_ts_queue;
    import ts_q_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ts_queue_if qif ();

    ts_queue #(.DEPTH(16), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (qif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    entry_t sb[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge: inputs already driven, sample #1 after the edge, then idle inputs.
    task automatic step();
        logic c, p, r;
        c = qif.capture_in; p = qif.q_rd_en_in; r = qif.q_rst_in;
        @(posedge clk);
        #1;
        $display("[TB] cap=%0b pop=%0b qrst=%0b -> stat=%h head=%h", c, p, r,
                 qif.q_stat_out, qif.q_data_out);
        qif.capture_in = 1'b0;
        qif.q_rd_en_in = 1'b0;
        qif.q_rst_in   = 1'b0;
    endtask

    task automatic set_cap(input logic [47:0] sec, input logic [37:0] ns);
        qif.capture_in      = 1'b1;
        qif.time_reg_sec_in = sec;
        qif.time_reg_ns_in  = ns;
    endtask

    task automatic qclear();
        qif.q_rst_in = 1'b1;
        step();
    endtask

    task automatic fill16();
        for (int i = 1; i <= 16; i++) begin
            set_cap(48'(i), 38'(i));
            step();
        end
    endtask

    initial begin
        rst = 1'b0;
        qif.capture_in      = 1'b0;
        qif.q_rd_en_in      = 1'b0;
        qif.q_rst_in        = 1'b0;
        qif.time_reg_ns_in  = '0;
        qif.time_reg_sec_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_stat", 64'(qif.q_stat_out), 64'h00);
        check_val("reset_data", 64'(qif.q_data_out), 64'h0);

        // Scenario 1: capture on the first edge after reset release, then pop.
        rst = 1'b1;
        set_cap(48'h0000_0002_0003, 38'h0000000155);
        step();
        check_val("s1_stat", 64'(qif.q_stat_out), 64'h01);
        check_val("s1_data", 64'(qif.q_data_out), 64'({18'h20003, 38'h155}));
        qif.q_rd_en_in = 1'b1;
        step();
        check_val("s1_pop_stat", 64'(qif.q_stat_out), 64'h00);
        check_val("s1_pop_data", 64'(qif.q_data_out), 64'h0);

        // Scenario 2: fill then overflow.
        fill16();
        check_val("s2_full_stat", 64'(qif.q_stat_out), 64'h30);
        check_val("s2_full_head", 64'(qif.q_data_out), 64'({18'd1, 38'd1}));
        set_cap(48'd17, 38'd17);
        step();
        check_val("s2_ovf_stat", 64'(qif.q_stat_out), 64'hB0);
        check_val("s2_ovf_head", 64'(qif.q_data_out), 64'({18'd1, 38'd1}));

        // Scenario 3: full queue, simultaneous capture and pop.
        qclear();
        check_val("s3_clear", 64'(qif.q_stat_out), 64'h00);
        fill16();
        set_cap(48'd17, 38'd17);
        qif.q_rd_en_in = 1'b1;
        step();
        check_val("s3_stat", 64'(qif.q_stat_out), 64'h30);
        for (int k = 2; k <= 17; k++) begin
            check_val($sformatf("s3_head%0d", k), 64'(qif.q_data_out), 64'({18'(k), 38'(k)}));
            qif.q_rd_en_in = 1'b1;
            step();
        end
        check_val("s3_drained", 64'(qif.q_stat_out), 64'h00);

        // Scenario 4: underflow, then capture+pop on empty.
        qif.q_rd_en_in = 1'b1;
        step();
        check_val("s4_udf_stat", 64'(qif.q_stat_out), 64'h40);
        check_val("s4_udf_data", 64'(qif.q_data_out), 64'h0);
        set_cap(48'h3, 38'h55);
        qif.q_rd_en_in = 1'b1;
        step();
        check_val("s4_cap_pop_stat", 64'(qif.q_stat_out), 64'h41);
        check_val("s4_cap_pop_data", 64'(qif.q_data_out), 64'({18'h3, 38'h55}));

        // Scenario 5: interleaved capture/pop across pointer wrap vs scoreboard.
        qclear();
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            set_cap(48'(500 + i), 38'(500 + i));
            sb.push_back({18'(500 + i), 38'(500 + i)});
            step();
        end
        for (int i = 0; i < 40; i++) begin
            check_val($sformatf("s5_head%0d", i), 64'(qif.q_data_out), 64'(sb[0]));
            set_cap(48'h1_0000 + 48'(i), 38'(1000 + i));
            qif.q_rd_en_in = 1'b1;
            void'(sb.pop_front());
            sb.push_back({18'h1_0000 + 18'(i), 38'(1000 + i)});
            step();
        end
        check_val("s5_stat", 64'(qif.q_stat_out), 64'h03);
        while (sb.size() > 0) begin
            check_val("s5_drain", 64'(qif.q_data_out), 64'(sb[0]));
            void'(sb.pop_front());
            qif.q_rd_en_in = 1'b1;
            step();
        end
        check_val("s5_empty", 64'(qif.q_stat_out), 64'h00);

        // Scenario 6: queue clear overrides capture; async reset mid-burst.
        fill16();
        set_cap(48'd99, 38'd99);
        step();
        for (int i = 0; i < 11; i++) begin
            qif.q_rd_en_in = 1'b1;
            step();
        end
        check_val("s6_pre_stat", 64'(qif.q_stat_out), 64'h85);
        check_val("s6_pre_head", 64'(qif.q_data_out), 64'({18'd12, 38'd12}));
        qif.q_rst_in = 1'b1;
        set_cap(48'd7, 38'd7);
        step();
        check_val("s6_qrst_stat", 64'(qif.q_stat_out), 64'h00);
        check_val("s6_qrst_data", 64'(qif.q_data_out), 64'h0);
        for (int i = 0; i < 3; i++) begin
            set_cap(48'(40 + i), 38'(40 + i));
            step();
        end
        check_val("s6_burst_stat", 64'(qif.q_stat_out), 64'h03);
        set_cap(48'd50, 38'd50);
        #2;
        rst = 1'b0;
        #1;
        check_val("s6_async_stat", 64'(qif.q_stat_out), 64'h00);
        check_val("s6_async_data", 64'(qif.q_data_out), 64'h0);
        @(posedge clk);
        #1;
        check_val("s6_in_reset_stat", 64'(qif.q_stat_out), 64'h00);
        rst = 1'b1;
        set_cap(48'd77, 38'd77);
        step();
        check_val("s6_release_stat", 64'(qif.q_stat_out), 64'h01);
        check_val("s6_release_data", 64'(qif.q_data_out), 64'({18'd77, 38'd77}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
